// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core port, external port and memory-side signals of the unified memory arbiter
interface mem_arbiter_if;
  logic        c_req, c_we, x_req, x_we;
  logic [31:0] c_addr, c_wdata, x_addr, x_wdata;
  logic        c_gnt, x_gnt, c_rvalid, x_rvalid;
  logic [31:0] c_rdata, x_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, x_req, x_we, x_addr, x_wdata, mem_rdata,
    output c_gnt, x_gnt, c_rvalid, x_rvalid, c_rdata, x_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, x_req, x_we, x_addr, x_wdata, mem_rdata,
    input  c_gnt, x_gnt, c_rvalid, x_rvalid, c_rdata, x_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and fixed-latency access sequencer for the unified memory
module mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..4");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t     state;
  logic       sel;
  logic       last;
  logic       we_r;
  logic [2:0] cnt;
  logic       pick;
  // winner of the current arbitration: a lone requester, or on a tie the port that did not go last
  always_comb pick = (bus.c_req && bus.x_req) ? !last : bus.x_req;
  // strobes and grants are decoded from the state register so no request reaches them combinationally
  assign bus.mem_en = state == ISSUE;
  assign bus.mem_we = state == ISSUE && we_r;
  assign bus.c_gnt  = state == ISSUE && !sel;
  assign bus.x_gnt  = state == ISSUE && sel;
  assign bus.busy   = state != IDLE;
  // sequencer: latch the winner, issue one access, count the read latency, return data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      sel           <= 1'b0;
      last          <= 1'b1;
      we_r          <= 1'b0;
      cnt           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.c_rdata   <= '0;
      bus.x_rdata   <= '0;
      bus.c_rvalid  <= 1'b0;
      bus.x_rvalid  <= 1'b0;
    end else begin
      bus.c_rvalid <= 1'b0;
      bus.x_rvalid <= 1'b0;
      case (state)
        IDLE: if (bus.c_req || bus.x_req) begin
          sel           <= pick;
          last          <= pick;
          we_r          <= pick ? bus.x_we : bus.c_we;
          bus.mem_addr  <= pick ? bus.x_addr : bus.c_addr;
          bus.mem_wdata <= pick ? bus.x_wdata : bus.c_wdata;
          state         <= ISSUE;
        end
        ISSUE: begin
          cnt   <= 3'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: if (cnt == 3'd1) begin
          if (!we_r && sel) bus.x_rdata <= bus.mem_rdata;
          if (!we_r && !sel) bus.c_rdata <= bus.mem_rdata;
          bus.x_rvalid <= sel;
          bus.c_rvalid <= !sel;
          state        <= IDLE;
        end else cnt <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the single unified instruction/data memory of the multicycle core. It shares the memory between the core's fetch/load/store traffic (port c) and an external loader/debug port (port x). Requests are granted round-robin, one transaction is in flight at a time, and the block counts a fixed memory read latency before returning data. It sits between the core datapath's memory interface and the memory macro.

## Interface
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4; any other value is an elaboration error.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- c_req / x_req  in  1  request from core / external port
- c_we / x_we  in  1  1 = write, 0 = read
- c_addr / x_addr  in  32  byte address, passed through unmodified
- c_wdata / x_wdata  in  32  write data
- c_gnt / x_gnt  out  1  one-cycle pulse: request issued to memory this cycle
- c_rvalid / x_rvalid  out  1  one-cycle completion pulse (reads and writes)
- c_rdata / x_rdata  out  32  registered read data per port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req is high, register the winner (sel) and its we/addr/wdata, then go to ISSUE. Otherwise stay.
- Arbitration in IDLE:
  - A single requester always wins.
  - If both request, the port not equal to `last` wins.
  - `last` updates to sel on entry to ISSUE. Reset value of `last` is x, so the core wins the first tie.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the registered request.
  - The gnt of sel pulses.
  - Load the latency counter with MEM_LATENCY, then go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1: capture mem_rdata into sel's rdata (reads only), set sel's rvalid for the next cycle, and go to IDLE.
- For writes, rdata keeps its previous value; rvalid still pulses.
- The other port's rdata is never modified.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req in the cycle after gnt unless issuing a new request.
  - A request raised while busy waits in IDLE arbitration; it is not dropped.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Reset, asynchronous and valid in any state:
  - state=IDLE, last=x.
  - All gnt, rvalid, mem_en, mem_we and busy = 0.
  - mem_addr, mem_wdata, c_rdata and x_rdata = 0.
  - An in-flight transaction is aborted with no rvalid; a write already strobed into memory is not undone.

## Timing
- Request seen in IDLE during cycle T:
  - gnt and mem_en in cycle T+1.
  - mem_rdata sampled in cycle T+MEM_LATENCY+1.
  - rvalid and new rdata visible in cycle T+MEM_LATENCY+2, when the FSM is back in IDLE.
- In the rvalid cycle the FSM is in IDLE and arbitrates new requests. Back-to-back period is MEM_LATENCY+2 cycles.
- busy is high from T+1 through T+MEM_LATENCY+1.
- gnt and rvalid are never high on both ports in the same cycle.
- All outputs are registered except mem_en, mem_we and gnt, which are decoded from the state register (no req-to-output combinational path).

## Test plan
- Reset, MEM_LATENCY=1:
  - Stimulus: drop rst mid-WAIT.
  - Response: all outputs 0 immediately (asynchronously); no rvalid after release.
- Core read, MEM_LATENCY=1:
  - Stimulus: c_req=1, c_addr=0x100 in cycle T; memory returns 0xDEADBEEF.
  - Response: c_gnt and mem_en at T+1 with mem_addr=0x100; c_rvalid at T+3 with c_rdata=0xDEADBEEF; x_rdata unchanged.
- External write, MEM_LATENCY=3:
  - Stimulus: x_req=1, x_we=1, x_addr=0x20, x_wdata=0x12345678.
  - Response: mem_we=1 and mem_wdata=0x12345678 at T+1; x_rvalid at T+5; x_rdata unchanged; busy high T+1..T+4.
- Simultaneous requests after reset, both held continuously:
  - Response: grants alternate c, x, c, x, each MEM_LATENCY+2 cycles apart.
- Request while busy:
  - Stimulus: x_req raised during core WAIT.
  - Response: x_gnt exactly one cycle after c_rvalid.
- Latency sweep:
  - Stimulus: MEM_LATENCY=2 and 4 with read-after-write to the same address.
  - Response: read returns the written value; rvalid at T+MEM_LATENCY+2.
